// File: rtl/c_74lvc_down_counter.sv
// 4-bit presettable synchronous binary down counter, 74LVC style, with async master reset.
// Define C_DOWN_AUTORELOAD_EN to reload D on the count edge at 0000 (divide-by-(D+1)).
module c_74lvc_down_counter (
  input  logic       cp,
  input  logic       cr,
  input  logic       pe,
  input  logic       cep,
  input  logic       cet,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc
);

  logic       count_en;
  logic       at_zero;
  logic [3:0] q_next;

  assign count_en = cep & cet;
  assign at_zero  = (q == 4'd0);

  // Priority: load (pe low) beats count, count beats hold.
  always_comb begin
    q_next = q;
    if (!pe) begin
      q_next = d;
    end else if (count_en) begin
`ifdef C_DOWN_AUTORELOAD_EN
      if (at_zero) begin
        q_next = d;
      end else begin
        q_next = q - 4'd1;
      end
`else
      q_next = q - 4'd1;
`endif
    end
  end

  always_ff @(posedge cp or negedge cr) begin
    if (!cr) begin
      q <= 4'd0;
    end else begin
      q <= q_next;
    end
  end

  // Borrow is combinational so it follows cet within the cycle for ripple cascading.
  assign tc = cet & at_zero;

endmodule

// File: tb/tb_c_74lvc_down_counter.sv
// Self-checking bench for c_74lvc_down_counter: directed scenarios followed by random traffic,
// compared against an arithmetic reference model of the counter rules.
module tb_c_74lvc_down_counter;

  logic       cp;
  logic       cr;
  logic       pe;
  logic       cep;
  logic       cet;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;

  int model_q;
  int checks;
  int passed;
  int failed;

  c_74lvc_down_counter dut (
    .cp  (cp),
    .cr  (cr),
    .pe  (pe),
    .cep (cep),
    .cet (cet),
    .d   (d),
    .q   (q),
    .tc  (tc)
  );

  // Clock: period 100, rising edges at 50, 150, ...
  initial begin
    cp = 1'b0;
    forever #50 cp = ~cp;
  end

  // Reference: next count value from the counter rules, in plain integer arithmetic.
  function automatic int ref_next(int cur, logic r, logic p, logic ep, logic et, logic [3:0] dv);
    if (!r) return 0;
    if (!p) return int'(dv);
    if (ep && et) begin
`ifdef C_DOWN_AUTORELOAD_EN
      if (cur == 0) return int'(dv);
`endif
      return (cur + 15) % 16;
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_q;
    logic [3:0] exp_tc;
    exp_q  = 4'(model_q);
    exp_tc = {3'b000, (cet === 1'b1) && (model_q == 0)};
    check({tag, "_q"}, q, exp_q);
    check({tag, "_tc"}, {3'b000, tc}, exp_tc);
  endtask

  // One rising edge: update the model from inputs at the edge, then sample 1 unit later.
  task automatic step(input string tag);
    @(posedge cp);
    model_q = ref_next(model_q, cr, pe, cep, cet, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #10 cr = 1'b0;
    model_q = 0;
    #1;
    check_outputs(tag);
    #5 cr = 1'b1;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    failed  = 0;
    model_q = 0;
    cr  = 1'b1;
    pe  = 1'b1;
    cep = 1'b1;
    cet = 1'b1;
    d   = 4'b1110;

    // Async reset before any edge
    #15 cr = 1'b0;
    model_q = 0;
    #10;
    check("rst_before_edge_q", q, 4'b0000);
    check("rst_tc", {3'b000, tc}, 4'b0001);
    #10 cr = 1'b1;
    step("first_count");

    // Count and wrap: 17 edges from 0000
    async_reset_pulse("wrap_rst");
    for (int i = 0; i < 17; i++) step("wrap_seq");

    // Load priority over count
    pe = 1'b0; d = 4'b0101;
    step("load_0101");
    d = 4'b1110;
    step("load_prio");
    pe = 1'b1;
    step("after_load");

    // Hold and TC gating by cet
    async_reset_pulse("hold_rst");
    #5 cet = 1'b0;
    #1 check_outputs("tc_falls");
    for (int i = 0; i < 3; i++) step("hold_cet0");
    cet = 1'b1; cep = 1'b0;
    #1 check_outputs("tc_cep0");
    step("hold_cep0");

    // D changes between edges have no effect
    cep = 1'b1;
    step("count_again");
    #10 d = 4'b0001;
    #10 d = 4'b1001;
    step("d_ignored");

    // Reset mid-operation with Q=1010
    pe = 1'b0; d = 4'b1010;
    step("load_1010");
    pe = 1'b1;
    #9 cr = 1'b0;
    model_q = 0;
    #1 check_outputs("mid_rst");
    step("rst_hold1");
    step("rst_hold2");
    #10 cr = 1'b1;
    step("resume");

    // Load 0000 asserts TC in the following cycle
    pe = 1'b0; d = 4'b0000; cet = 1'b1;
    step("load_zero");
    pe = 1'b1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      pe  = ($urandom_range(0, 7) != 0);
      cep = ($urandom_range(0, 3) != 0);
      cet = ($urandom_range(0, 3) != 0);
      d   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        async_reset_pulse("rnd_rst");
      end
      #5;
      check_outputs("rnd_mid");
      step("rnd_edge");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
